// File: rtl/i2s_tx_stream.sv
// i2s_tx_stream: stereo I2S / left-justified serial transmitter with a one-pair
// stream holding buffer, underrun handling, frame-aligned mute and clean start/stop.
`default_nettype none

module i2s_tx_stream #(
    parameter int DATA_W        = 16,
    parameter int MCLK_LOG2     = 1,
    parameter int SCLK_LOG2     = 2,
    parameter int SLOT_LOG2     = 5,
    parameter bit UNDERRUN_HOLD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_play,
    input  logic              i_fmt,
    input  logic              i_mute,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [DATA_W-1:0] i_s_left,
    input  logic [DATA_W-1:0] i_s_right,
    output logic              o_mclk,
    output logic              o_sclk,
    output logic              o_lrck,
    output logic              o_sdout,
    output logic              o_frame_start,
    output logic              o_underrun
);

    localparam int CW = MCLK_LOG2 + SCLK_LOG2 + SLOT_LOG2 + 1;
    localparam int PL = MCLK_LOG2 + SCLK_LOG2;
    localparam int PW = SLOT_LOG2 + 1;
    localparam logic [PW-1:0] C_P_S_M1  = PW'((1 << SLOT_LOG2) - 1);
    localparam logic [PW-1:0] C_P_2S_M2 = PW'((2 << SLOT_LOG2) - 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_buf_full;
    logic [DATA_W-1:0]   r_buf_l, r_buf_r;
    logic [DATA_W-1:0]   r_act_l, r_act_r;
    logic                r_fmt, r_mute;

    logic                w_cnt_max, w_start, w_stop, w_run_nxt, w_take, w_buf_full_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [DATA_W-1:0]   w_new_l, w_new_r, w_act_l, w_act_r, w_samp, w_shift;
    logic                w_fmt, w_mute, w_right, w_lrck, w_bit;
    logic [PW-1:0]       w_p;
    logic [SLOT_LOG2-1:0] w_k;

    assign w_cnt_max = &r_cnt;
    assign w_start   = (r_state == ST_IDLE && i_play) || (r_state == ST_RUN && w_cnt_max && i_play);
    assign w_stop    = (r_state == ST_RUN) && w_cnt_max && !i_play;
    assign w_run_nxt = w_start || (r_state == ST_RUN && !w_stop);
    // Entering RUN from IDLE keeps the counter at 0 so that cycle is the first of the frame.
    assign w_cnt_nxt = (r_state == ST_RUN && !w_stop) ? r_cnt + 1'b1 : '0;

    assign w_take         = i_s_valid && o_s_ready;
    assign w_buf_full_nxt = w_take ? 1'b1 : ((w_start && r_buf_full) ? 1'b0 : r_buf_full);

    assign w_new_l = r_buf_full ? r_buf_l : (UNDERRUN_HOLD ? r_act_l : '0);
    assign w_new_r = r_buf_full ? r_buf_r : (UNDERRUN_HOLD ? r_act_r : '0);

    // Outputs are registered from the next counter value, so the frame-start edge
    // must see the pair and controls being latched on that same edge.
    assign w_act_l = w_start ? w_new_l : r_act_l;
    assign w_act_r = w_start ? w_new_r : r_act_r;
    assign w_fmt   = w_start ? i_fmt   : r_fmt;
    assign w_mute  = w_start ? i_mute  : r_mute;

    assign w_p     = w_cnt_nxt[CW-1:PL];
    assign w_k     = w_p[SLOT_LOG2-1:0];
    assign w_right = w_p[SLOT_LOG2];
    assign w_samp  = w_right ? w_act_r : w_act_l;
    // Bits past the sample width shift out to zero, which pads the slot tail.
    assign w_shift = w_samp << w_k;
    assign w_bit   = w_shift[DATA_W-1] & ~w_mute;
    assign w_lrck  = w_fmt ? ~w_right : ((w_p >= C_P_S_M1) && (w_p <= C_P_2S_M2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_buf_full    <= 1'b0;
            r_buf_l       <= '0;
            r_buf_r       <= '0;
            r_act_l       <= '0;
            r_act_r       <= '0;
            r_fmt         <= 1'b0;
            r_mute        <= 1'b0;
            o_s_ready     <= 1'b1;
            o_mclk        <= 1'b0;
            o_sclk        <= 1'b0;
            o_lrck        <= 1'b0;
            o_sdout       <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            r_state    <= w_run_nxt ? ST_RUN : ST_IDLE;
            r_cnt      <= w_cnt_nxt;
            r_buf_full <= w_buf_full_nxt;
            o_s_ready  <= ~w_buf_full_nxt;
            if (w_take) begin
                r_buf_l <= i_s_left;
                r_buf_r <= i_s_right;
            end
            if (w_start) begin
                r_act_l <= w_new_l;
                r_act_r <= w_new_r;
                r_fmt   <= i_fmt;
                r_mute  <= i_mute;
            end
            if (w_run_nxt) begin
                o_mclk        <= w_cnt_nxt[MCLK_LOG2-1];
                o_sclk        <= w_cnt_nxt[PL-1];
                o_lrck        <= w_lrck;
                o_sdout       <= w_bit;
                o_frame_start <= w_start;
                o_underrun    <= w_start & ~r_buf_full;
            end else begin
                o_mclk        <= 1'b0;
                o_sclk        <= 1'b0;
                o_lrck        <= 1'b0;
                o_sdout       <= 1'b0;
                o_frame_start <= 1'b0;
                o_underrun    <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_stream.sv
// tb_i2s_tx_stream: directed bench for i2s_tx_stream with a pair scoreboard
// consumed at every frame start and a per-position sdout/lrck reference.
`default_nettype none

module tb_i2s_tx_stream;

    logic        clk = 1'b0;
    logic        rst_n, play, fmt, mute, s_valid;
    logic [15:0] s_left, s_right;
    logic        s_ready, mclk, sclk, lrck, sdout, frame_start, underrun;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    pair_t q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    i2s_tx_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_play       (play),
        .i_fmt        (fmt),
        .i_mute       (mute),
        .i_s_valid    (s_valid),
        .o_s_ready    (s_ready),
        .i_s_left     (s_left),
        .i_s_right    (s_right),
        .o_mclk       (mclk),
        .o_sclk       (sclk),
        .o_lrck       (lrck),
        .o_sdout      (sdout),
        .o_frame_start(frame_start),
        .o_underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] all_outs();
        return {mclk, sclk, lrck, sdout, frame_start, underrun, ~s_ready};
    endfunction

    task automatic push_idle(input pair_t pr);
        @(negedge clk);
        check("idle_ready_before_push", s_ready, 1);
        s_valid = 1'b1; s_left = pr.l; s_right = pr.r;
        @(negedge clk);
        check("idle_ready_after_push", s_ready, 0);
        s_valid = 1'b0;
        q.push_back(pr);
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        logic [6:0] seen = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen |= all_outs();
        end
        check(tag, {25'd0, seen}, 0);
    endtask

    // mute_act: 0 none, 1 raise mute at p10, 2 drop mute at p10.
    task automatic run_frame(input logic xfmt, input logic xmute, input bit do_push,
                             input pair_t nxt, input int mute_act, input bit drop_play,
                             input int abort_p);
        pair_t      exp;
        bit         ok = 0;
        int         p, k;
        logic [15:0] samp;
        logic       eb, el;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) ok = 1;
        end
        check("frame_start_seen", ok, 1);
        if (!ok) return;
        if (q.size() > 0) begin
            exp = q.pop_front();
            check("underrun_clear", underrun, 0);
        end else begin
            exp = '0;
            check("underrun_pulse", underrun, 1);
        end
        if (do_push) begin
            check("ready_at_start", s_ready, 1);
            s_valid = 1'b1; s_left = nxt.l; s_right = nxt.r;
        end
        for (int c = 0; c < 512; c++) begin
            if (c > 0) @(negedge clk);
            p = c / 8;
            if (c == 1) begin
                check("frame_start_one_cycle", frame_start, 0);
                check("underrun_one_cycle", underrun, 0);
                if (do_push) begin
                    s_valid = 1'b0;
                    check("ready_after_push", s_ready, 0);
                    q.push_back(nxt);
                end
            end
            if (c == 80) begin
                if (mute_act == 1) mute = 1'b1;
                if (mute_act == 2) mute = 1'b0;
                if (drop_play) play = 1'b0;
            end
            if (abort_p >= 0 && c == abort_p * 8) begin
                rst_n = 1'b0;
                #1;
                check("async_reset_outputs", {25'd0, all_outs()}, 0);
                q.delete();
                play = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check("mclk", mclk, c & 1);
            check("sclk", sclk, (c >> 2) & 1);
            if (c % 8 == 4) begin
                k    = p % 32;
                samp = (p < 32) ? exp.l : exp.r;
                eb   = (!xmute && k < 16) ? samp[15-k] : 1'b0;
                el   = xfmt ? (p < 32) : (p >= 31 && p <= 62);
                check($sformatf("sdout_p%0d", p), sdout, eb);
                check($sformatf("lrck_p%0d", p), lrck, el);
            end
            if (c == 511 && do_push) check("ready_low_to_frame_end", s_ready, 0);
        end
    endtask

    initial begin
        pair_t p1 = '{l: 16'hA5C3, r: 16'h0F01};
        pair_t p2 = '{l: 16'h8001, r: 16'h7FFE};
        pair_t p3 = '{l: 16'h1234, r: 16'hFEDC};
        pair_t p4 = '{l: 16'h55AA, r: 16'hAA55};
        pair_t p5 = '{l: 16'hC0DE, r: 16'h3F00};
        pair_t p6 = '{l: 16'hFFFF, r: 16'hFFFF};
        pair_t nul = '0;

        rst_n = 1'b0; play = 1'b0; fmt = 1'b0; mute = 1'b0;
        s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'd0, all_outs()}, 0);
        rst_n = 1'b1;
        quiet_cycles("idle_after_reset_quiet", 1000);

        push_idle(p1);
        play = 1'b1;
        run_frame(1'b0, 1'b0, 1'b1, p1, 0, 1'b0, -1);   // I2S, pair A5C3/0F01
        fmt = 1'b1;
        run_frame(1'b1, 1'b0, 1'b0, nul, 0, 1'b0, -1);  // left-justified, same pair
        run_frame(1'b1, 1'b0, 1'b1, p2, 0, 1'b0, -1);   // underrun, zeros
        run_frame(1'b1, 1'b0, 1'b1, p3, 1, 1'b0, -1);   // mute raised mid-frame
        run_frame(1'b1, 1'b1, 1'b1, p4, 2, 1'b0, -1);   // muted frame consumes p3
        fmt = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0, nul, 0, 1'b1, -1);  // play dropped at p10
        quiet_cycles("idle_after_stop_quiet", 40);

        push_idle(p5);
        play = 1'b1;
        run_frame(1'b0, 1'b0, 1'b1, p6, 0, 1'b0, 20);   // reset at p20
        check("ready_after_reset", s_ready, 1);
        quiet_cycles("idle_after_async_reset", 20);
        play = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0, nul, 0, 1'b1, -1);  // buffered pair was lost
        quiet_cycles("idle_final_quiet", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
